alu_arbiter: RTL and testbench



---
 rtl/alu_arb_pkg.sv | 17 +
 rtl/alu_rr_pick.sv | 25 ++
 rtl/alu_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and default widths for the two-requester ALU arbiter.
package alu_arb_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int SEL_W_DEF  = 4;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    // Identifies one of the two requesters.
    typedef logic req_id_t;

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way round-robin picker: produces a one-hot grant among the valid
// requesters, favouring the one that was not served last.
module alu_rr_pick
    import alu_arb_pkg::*;
(
    input  logic [1:0] req_valid,
    input  req_id_t    last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    // Lone requester wins outright; on contention priority rotates away from last_grant.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant == 1'b1) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters. A round-robin winner's
// operands are registered onto the ALU for one cycle, the result is captured
// and returned with the winner's id over a valid/ready response channel.
// Optional build macro ALU_ARB_STATS_EN adds saturating per-requester
// completed-operation counters op_cnt0/op_cnt1.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    input  logic [2*SEL_W-1:0]  req_sel,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [SEL_W-1:0]    alu_sel,
    input  logic [DATA_W-1:0]   alu_x,
    input  logic                alu_o,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [DATA_W-1:0]   rsp_x,
    output logic                rsp_o
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]    op_cnt0,
    output logic [CNT_W-1:0]    op_cnt1
`endif
);

    arb_state_e        state_q, state_d;
    req_id_t           last_grant_q, last_grant_d;
    req_id_t           id_q, id_d;
    req_id_t           rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
    logic [DATA_W-1:0] rsp_x_q, rsp_x_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_o_q, rsp_o_d;

    logic [1:0]        grant;
    logic              accept;
    req_id_t           win_id;

    // Grants are only offered while idle, so a busy ALU never accepts.
    alu_rr_pick u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .enable     (state_q == IDLE),
        .grant      (grant)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign win_id    = grant[1];

    // Next-state and datapath capture for the IDLE -> DRIVE -> RESP cycle.
    always_comb begin
        // NOTE: every _d takes its hold value first so no branch leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_x_d      = rsp_x_q;
        rsp_o_d      = rsp_o_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d      = win_id;
                    alu_a_d   = win_id ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
                    alu_b_d   = win_id ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
                    alu_sel_d = win_id ? req_sel[2*SEL_W-1:SEL_W] : req_sel[SEL_W-1:0];
                    state_d   = DRIVE;
                end
            end
            DRIVE: begin
                // ALU inputs have been stable for a full cycle; capture its result.
                rsp_x_d     = alu_x;
                rsp_o_d     = alu_o;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    last_grant_d = rsp_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_x_q      <= '0;
            rsp_o_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_x_q      <= rsp_x_d;
            rsp_o_q      <= rsp_o_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_x     = rsp_x_q;
    assign rsp_o     = rsp_o_q;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] op_cnt0_q, op_cnt0_d;
    logic [CNT_W-1:0] op_cnt1_q, op_cnt1_d;
    logic             rsp_fire;

    assign rsp_fire = rsp_valid_q & rsp_ready;

    // Bump the owner's counter on each consumed response, holding at all-ones.
    always_comb begin
        op_cnt0_d = op_cnt0_q;
        op_cnt1_d = op_cnt1_q;
        if (rsp_fire) begin
            if (rsp_id_q == 1'b0) begin
                if (op_cnt0_q != '1) op_cnt0_d = op_cnt0_q + CNT_W'(1);
            end else begin
                if (op_cnt1_q != '1) op_cnt1_d = op_cnt1_q + CNT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt0_q <= '0;
            op_cnt1_q <= '0;
        end else begin
            op_cnt0_q <= op_cnt0_d;
            op_cnt1_q <= op_cnt1_d;
        end
    end

    assign op_cnt0 = op_cnt0_q;
    assign op_cnt1 = op_cnt1_q;
`else
    // CNT_W only sizes the stats counters, which are absent in this build.
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. A behavioural model tracks busy/idle,
// the last served requester and the expected ALU operands; expected responses
// go into a scoreboard queue that a negedge monitor compares against the DUT.
// Build with ALU_ARB_STATS_EN defined to also check the op counters.
module tb_alu_arbiter;

    localparam int DATA_W = 4;
    localparam int SEL_W  = 4;
    localparam int CNT_W  = 8;

    typedef struct packed {
        logic       id;
        logic [3:0] x;
        logic       o;
    } rsp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*DATA_W-1:0] req_a;
    logic [2*DATA_W-1:0] req_b;
    logic [2*SEL_W-1:0]  req_sel;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [SEL_W-1:0]    alu_sel;
    logic [DATA_W-1:0]   alu_x;
    logic                alu_o;
    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic [DATA_W-1:0]   rsp_x;
    logic                rsp_o;
`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0]    op_cnt0;
    logic [CNT_W-1:0]    op_cnt1;
`endif

    alu_arbiter #(.DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_x     (alu_x),
        .alu_o     (alu_o),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_x     (rsp_x),
        .rsp_o     (rsp_o)
`ifdef ALU_ARB_STATS_EN
        ,
        .op_cnt0   (op_cnt0),
        .op_cnt1   (op_cnt1)
`endif
    );

    always #5 clk = ~clk;

    // ALU stub: 4-bit add with carry out, select ignored.
    assign {alu_o, alu_x} = {1'b0, alu_a} + {1'b0, alu_b};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: one requester wins alone; two contend and the one not served last wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] v, input logic last);
        int w;
        if (v == 2'b00) return 2'b00;
        if (v == 2'b11) w = (last == 1'b0) ? 1 : 0;
        else            w = v[1] ? 1 : 0;
        return 2'(1 << w);
    endfunction

    // Model state (owned by the monitor).
    rsp_t       exp_q[$];
    rsp_t       obs_log[$];
    bit         m_busy;
    logic       m_last;
    int         m_acc_cycle;
    logic [3:0] m_a, m_b, m_sel;
    int         m_cnt0, m_cnt1;
    int         cycle = 0;

    task automatic model_reset();
        exp_q.delete();
        m_busy      = 1'b0;
        m_last      = 1'b1;
        m_acc_cycle = 0;
        m_a         = '0;
        m_b         = '0;
        m_sel       = '0;
        m_cnt0      = 0;
        m_cnt1      = 0;
    endtask

    // Monitor: compare DUT against the model every cycle, then advance the model.
    initial begin
        logic [1:0] exp_ready;
        logic       exp_rsp_valid;
        logic [4:0] sum;
        rsp_t       r;
        int         w;
        model_reset();
        forever begin
            @(negedge clk);
            cycle++;
            exp_ready     = m_busy ? 2'b00 : rr_pick(req_valid, m_last);
            exp_rsp_valid = m_busy && (cycle >= m_acc_cycle + 2);
            check("req_ready", req_ready, exp_ready);
            check("rsp_valid", rsp_valid, exp_rsp_valid);
            check("alu_a", alu_a, m_a);
            check("alu_b", alu_b, m_b);
            check("alu_sel", alu_sel, m_sel);
            if (rsp_valid && exp_q.size() > 0) begin
                check("rsp_id", rsp_id, exp_q[0].id);
                check("rsp_x", rsp_x, exp_q[0].x);
                check("rsp_o", rsp_o, exp_q[0].o);
            end
`ifdef ALU_ARB_STATS_EN
            check("op_cnt0", op_cnt0, m_cnt0);
            check("op_cnt1", op_cnt1, m_cnt1);
`endif
            if (rsp_valid && rsp_ready && !rst) obs_log.push_back({rsp_id, rsp_x, rsp_o});

            if (rst) begin
                model_reset();
            end else if (!m_busy && exp_ready != 2'b00) begin
                w     = exp_ready[1] ? 1 : 0;
                m_a   = req_a[w*4 +: 4];
                m_b   = req_b[w*4 +: 4];
                m_sel = req_sel[w*4 +: 4];
                sum   = {1'b0, m_a} + {1'b0, m_b};
                exp_q.push_back({w[0], sum[3:0], sum[4]});
                m_busy      = 1'b1;
                m_acc_cycle = cycle;
            end else if (exp_rsp_valid && rsp_ready && exp_q.size() > 0) begin
                r = exp_q.pop_front();
                m_last = r.id;
                m_busy = 1'b0;
                if (r.id == 1'b0) m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
                else              m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "simulation time limit reached");
    end

    // Stimulus.
    initial begin
        int n;
        int base;
        bit found;
        rst       = 1'b1;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        rsp_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;

        // 1: single request from requester 0.
        req_valid = 2'b01;
        req_a     = {4'h0, 4'b1100};
        req_b     = {4'h0, 4'b1010};
        req_sel   = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t1_req_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        n = 0;
        found = 1'b0;
        while (n < 10 && !found) begin
            @(negedge clk);
            n++;
            if (rsp_valid) found = 1'b1;
        end
        check("t1_latency", n, 2);
        check("t1_rsp_id", rsp_id, 1'b0);
        check("t1_rsp_x", rsp_x, 4'b0110);
        check("t1_rsp_o", rsp_o, 1'b1);
        repeat (3) step();

        // 2: contention right after reset, both held valid.
        rst = 1'b1;
        step();
        rst = 1'b0;
        obs_log.delete();
        req_valid = 2'b11;
        req_a     = {4'b0001, 4'h7};
        req_b     = {4'b0010, 4'h8};
        req_sel   = {4'h3, 4'h5};
        repeat (12) step();
        req_valid = 2'b00;
        repeat (3) step();
        check("t2_count", obs_log.size(), 4);
        for (int i = 0; i < 4 && i < obs_log.size(); i++) begin
            check("t2_order", obs_log[i].id, i % 2);
            if (obs_log[i].id == 1'b1) begin
                check("t2_req1_x", obs_log[i].x, 4'b0011);
                check("t2_req1_o", obs_log[i].o, 1'b0);
            end
        end

        // 3: response backpressure with both requesters pending.
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        req_a     = {4'h9, 4'hF};
        req_b     = {4'h9, 4'h3};
        repeat (7) step();
        check("t3_held_valid", rsp_valid, 1'b1);
        check("t3_ready_blocked", req_ready, 2'b00);
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        step();
        check("t3_completed", rsp_valid, 1'b0);
        repeat (3) step();

        // 4: reset while the ALU is being driven.
        req_valid = 2'b01;
        req_a     = {4'h0, 4'h5};
        req_b     = {4'h0, 4'h9};
        req_sel   = {4'h0, 4'h7};
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t4_rsp_valid", rsp_valid, 1'b0);
        check("t4_alu_a", alu_a, 4'h0);
        check("t4_alu_b", alu_b, 4'h0);
        check("t4_alu_sel", alu_sel, 4'h0);
        check("t4_req_ready", req_ready, 2'b01);
        req_valid = 2'b00;
        repeat (4) step();

        // 5: requester 1 withdraws before the block returns to idle.
        base      = obs_log.size();
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        req_a     = {4'hA, 4'h2};
        req_b     = {4'hA, 4'h2};
        step();
        req_valid = 2'b00;
        step();
        req_valid = 2'b10;
        repeat (2) step();
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (4) step();
        check("t5_rsp_count", obs_log.size() - base, 1);
        if (obs_log.size() > base) check("t5_rsp_owner", obs_log[base].id, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_a     = 8'($urandom);
            req_b     = 8'($urandom);
            req_sel   = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 49) == 0);
            step();
        end
        rst       = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (6) step();

`ifdef ALU_ARB_STATS_EN
        // 6: saturate requester 0's counter.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 2'b01;
        for (int i = 0; i < 300; i++) begin
            req_a = 8'($urandom);
            req_b = 8'($urandom);
            repeat (3) step();
        end
        req_valid = 2'b00;
        repeat (4) step();
        check("t6_op_cnt0", op_cnt0, 8'hFF);
        check("t6_op_cnt1", op_cnt1, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
